// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: serializes a parallel word into a WIDTH-stage shift chain,
// with stall and abort, one-cycle done pulse when the chain is full.
module shift_seq_ctrl #(
   parameter int WIDTH     = 4,
   parameter bit LSB_FIRST = 1'b0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   input  logic [WIDTH-1:0]           din,
   output logic                       in_ready,
   input  logic                       stall,
   input  logic                       abort,
   output logic                       ser_out,
   output logic                       shift_en,
   output logic [$clog2(WIDTH+1)-1:0] bit_cnt,
   output logic                       busy,
   output logic                       done
);
   localparam int CW = $clog2(WIDTH+1);
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   state_t           r_state, w_next;
   logic [WIDTH-1:0] r_shadow;
   logic [CW-1:0]    r_cnt;
   logic             w_last;
   always_comb begin
      w_last = r_cnt == CW'(WIDTH-1);
      w_next = r_state == IDLE  ? (in_valid ? SHIFT : IDLE) :
               r_state == SHIFT ? (abort ? IDLE : (!stall && w_last) ? DONE : SHIFT) :
               IDLE;
   end
   assign in_ready = r_state == IDLE;
   assign busy     = r_state != IDLE;
   assign done     = r_state == DONE;
   assign shift_en = r_state == SHIFT && !stall && !abort;
   assign ser_out  = r_state == SHIFT && (LSB_FIRST ? r_shadow[0] : r_shadow[WIDTH-1]);
   assign bit_cnt  = r_cnt;
   // bit_cnt keeps WIDTH after the word completes until the next handshake
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= IDLE;
         r_shadow <= '0;
         r_cnt    <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == IDLE && in_valid) begin
            r_shadow <= din;
            r_cnt    <= '0;
         end else if (r_state == SHIFT && abort) begin
            r_cnt <= '0;
         end else if (shift_en) begin
            r_shadow <= LSB_FIRST ? r_shadow >> 1 : r_shadow << 1;
            r_cnt    <= r_cnt + CW'(1);
         end
      end
   end
endmodule
